// File: rtl/garuda_weight_pkg.sv
// Shared geometry, FSM state and job descriptor for the weight stream reader.
package garuda_weight_pkg;

    localparam int DEF_NUM_BANKS   = 4;
    localparam int DEF_ADDR_WIDTH  = 15;
    localparam int DEF_LEN_WIDTH   = 14;
    localparam int DEF_PASS_WIDTH  = 8;

    // The top address bits select the bank; the rest address a word inside it.
    localparam int BANK_SEL_WIDTH  = $clog2(DEF_NUM_BANKS);
    localparam int BANK_ADDR_WIDTH = DEF_ADDR_WIDTH - BANK_SEL_WIDTH;
    localparam int BANK_DEPTH      = 1 << BANK_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [BANK_ADDR_WIDTH-1:0] base;
        logic [DEF_LEN_WIDTH-1:0]   len;
        logic [BANK_ADDR_WIDTH-1:0] stride;
        logic [DEF_PASS_WIDTH-1:0]  passes;
    } job_t;

endpackage

// File: rtl/weight_lane_fifo.sv
// Per-lane output FIFO holding {data, last}; head outputs come straight from
// storage registers, and the clear input empties it in one cycle.
module weight_lane_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // An empty FIFO presents zeros so the lane outputs are quiet between jobs.
    assign head_data = empty ? '0 : mem[rd_ptr].data;
    assign head_last = empty ? 1'b0 : mem[rd_ptr].last;

    // Pointer and occupancy bookkeeping; clear wins over any push or pop.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
            if (do_push && !do_pop)      count <= count + CNT_WIDTH'(1);
            else if (do_pop && !do_push) count <= count - CNT_WIDTH'(1);
        end
    end

    // Entry storage write.
    // NOTE: storage is deliberately not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{data: push_data, last: push_last};
    end

endmodule

// File: rtl/weight_stream_reader.sv
// Read-side sequencer: replays a strided tile from every bank in lockstep and
// streams bank n's words to lane n through a small per-lane FIFO.
module weight_stream_reader
    import garuda_weight_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int PASS_WIDTH = DEF_PASS_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic [ADDR_WIDTH-$clog2(NUM_BANKS)-1:0] base_i,
    input  logic [LEN_WIDTH-1:0]                   len_i,
    input  logic [ADDR_WIDTH-$clog2(NUM_BANKS)-1:0] stride_i,
    input  logic [PASS_WIDTH-1:0]                  passes_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o,
    output logic [NUM_BANKS-1:0]                   rd_en_o,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0]        rd_addr_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]        rd_data_i,
    input  logic [NUM_BANKS-1:0]                   rd_valid_i,
    output logic [NUM_BANKS-1:0]                   lane_valid_o,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]        lane_data_o,
    output logic [NUM_BANKS-1:0]                   lane_last_o,
    input  logic [NUM_BANKS-1:0]                   lane_ready_i
);

    // Wide enough for base + (len-1)*stride without any truncation.
    localparam int SPAN_WIDTH = LEN_WIDTH + BANK_ADDR_WIDTH + 1;

    state_t                     state_q, state_d;
    job_t                       job_q, job_d;
    logic [LEN_WIDTH-1:0]       idx_q, idx_d;
    logic [PASS_WIDTH-1:0]      pass_q, pass_d;
    logic [BANK_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       done_d, err_d;

    logic [NUM_BANKS-1:0]       full, empty, push;
    logic [SPAN_WIDTH-1:0]      span;
    logic                       job_ok, issue, read_fault, flush;
    logic                       last_word, final_word, fifo_clear;

    assign span = SPAN_WIDTH'(base_i)
                + SPAN_WIDTH'(len_i - LEN_WIDTH'(1)) * SPAN_WIDTH'(stride_i);
    assign job_ok = (len_i != '0) && (passes_i != '0)
                 && (span <= SPAN_WIDTH'(BANK_DEPTH - 1));

    // Reads issue in lockstep and stall globally while any lane is backed up.
    assign issue      = (state_q == ST_RUN) && !(|full);
    assign read_fault = issue && (rd_valid_i != '1);
    assign flush      = abort_i || read_fault;
    assign fifo_clear = rst_i || flush;

    assign last_word  = (idx_q == job_q.len - LEN_WIDTH'(1));
    assign final_word = last_word && (pass_q == job_q.passes - PASS_WIDTH'(1));

    assign busy_o       = (state_q != ST_IDLE);
    assign rd_en_o      = {NUM_BANKS{issue}};
    assign push         = {NUM_BANKS{issue && !flush}} & rd_valid_i;
    assign lane_valid_o = ~empty;

    for (genvar n = 0; n < NUM_BANKS; n++) begin : g_lane
        assign rd_addr_o[n*ADDR_WIDTH +: ADDR_WIDTH] =
            issue ? {BANK_SEL_WIDTH'(n), addr_q} : '0;

        weight_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_i),
            .clear     (fifo_clear),
            .push      (push[n]),
            .push_data (rd_data_i[n*DATA_WIDTH +: DATA_WIDTH]),
            .push_last (final_word),
            .pop       (lane_ready_i[n]),
            .head_data (lane_data_o[n*DATA_WIDTH +: DATA_WIDTH]),
            .head_last (lane_last_o[n]),
            .full      (full[n]),
            .empty     (empty[n])
        );
    end

    // Next-state, job latch, address walk and status pulses.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            err_d   = read_fault;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (job_ok) begin
                            state_d = ST_RUN;
                            job_d   = '{base: base_i, len: len_i, stride: stride_i, passes: passes_i};
                            idx_d   = '0;
                            pass_d  = '0;
                            addr_d  = base_i;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last_word) begin
                            idx_d  = '0;
                            addr_d = job_q.base;
                            pass_d = pass_q + PASS_WIDTH'(1);
                            if (final_word) state_d = ST_DRAIN;
                        end else begin
                            idx_d  = idx_q + LEN_WIDTH'(1);
                            addr_d = addr_q + job_q.stride;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (&empty) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            job_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            addr_q  <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            addr_q  <= addr_d;
            done_o  <= done_d;
            err_o   <= err_d;
        end
    end

endmodule

// File: tb/tb_weight_stream_reader.sv
// Scoreboard bench: job tasks queue the expected lane words, a negedge monitor
// pops and compares every accepted lane word, directed steps check control.
module tb_weight_stream_reader;

    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int AW  = 15;
    localparam int LW  = 14;
    localparam int PW  = 8;
    localparam int BAW = 13;

    logic              clk = 1'b0;
    logic              rst_i, start_i, abort_i;
    logic [BAW-1:0]    base_i, stride_i;
    logic [LW-1:0]     len_i;
    logic [PW-1:0]     passes_i;
    logic              busy_o, done_o, err_o;
    logic [NB-1:0]     rd_en_o, rd_valid_i, lane_valid_o, lane_last_o, lane_ready_i;
    logic [NB*AW-1:0]  rd_addr_o;
    logic [NB*DW-1:0]  rd_data_i, lane_data_o;
    logic [NB-1:0]     fault_mask;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [DW:0] exp_q [NB][$];
    logic [DW:0] prev_word [NB];
    logic        prev_stall [NB];
    logic [DW:0] got, want;

    always #5 clk = ~clk;

    weight_stream_reader dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .base_i       (base_i),
        .len_i        (len_i),
        .stride_i     (stride_i),
        .passes_i     (passes_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .rd_valid_i   (rd_valid_i),
        .lane_valid_o (lane_valid_o),
        .lane_data_o  (lane_data_o),
        .lane_last_o  (lane_last_o),
        .lane_ready_i (lane_ready_i)
    );

    // Buffer content is a fixed function of the full address.
    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return {1'b0, a, 1'b1, a};
    endfunction

    always_comb begin
        for (int n = 0; n < NB; n++)
            rd_data_i[n*DW +: DW] = word_at(rd_addr_o[n*AW +: AW]);
    end
    assign rd_valid_i = rd_en_o & ~fault_mask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each accepted lane word, and hold-stability under stall.
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int n = 0; n < NB; n++) begin
                got = {lane_data_o[n*DW +: DW], lane_last_o[n]};
                if (prev_stall[n] && lane_valid_o[n])
                    check($sformatf("lane%0d_hold", n), got, prev_word[n]);
                if (lane_valid_o[n] && lane_ready_i[n]) begin
                    if (exp_q[n].size() == 0) begin
                        check($sformatf("lane%0d_extra_word", n), exp_q[n].size(), 1);
                    end else begin
                        want = exp_q[n].pop_front();
                        check($sformatf("lane%0d_word", n), got, want);
                    end
                    last_pop_cyc = cyc;
                end
                prev_stall[n] = lane_valid_o[n] && !lane_ready_i[n];
                prev_word[n]  = got;
            end
            if (done_o) done_cnt++;
            if (err_o)  err_cnt++;
        end else begin
            for (int n = 0; n < NB; n++) prev_stall[n] = 1'b0;
        end
    end

    task automatic expect_job(input logic [BAW-1:0] b, input int l, input logic [BAW-1:0] s, input int p);
        logic [BAW-1:0] a;
        for (int pp = 0; pp < p; pp++)
            for (int i = 0; i < l; i++) begin
                a = BAW'(int'(b) + i * int'(s));
                for (int n = 0; n < NB; n++)
                    exp_q[n].push_back({word_at({2'(n), a}), (pp == p - 1) && (i == l - 1)});
            end
    endtask

    task automatic flush_expect();
        for (int n = 0; n < NB; n++) exp_q[n].delete();
    endtask

    function automatic int pending();
        int t = 0;
        for (int n = 0; n < NB; n++) t += exp_q[n].size();
        return t;
    endfunction

    task automatic start_job(input logic [BAW-1:0] b, input logic [LW-1:0] l,
                             input logic [BAW-1:0] s, input logic [PW-1:0] p);
        @(posedge clk); #1;
        base_i = b; len_i = l; stride_i = s; passes_i = p; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy_o && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, k < 500, 1);
        check({name, "_done_pulse"}, done_o, 1);
        check({name, "_done_latency"}, cyc - last_pop_cyc, 2);
        check({name, "_all_words_seen"}, pending(), 0);
    endtask

    task automatic try_bad(input string name, input logic [BAW-1:0] b, input logic [LW-1:0] l,
                           input logic [BAW-1:0] s, input logic [PW-1:0] p);
        int e0;
        logic busy_seen;
        @(posedge clk); #1;
        e0 = err_cnt;
        busy_seen = 1'b0;
        base_i = b; len_i = l; stride_i = s; passes_i = p; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            busy_seen |= busy_o;
        end
        #1;
        check({name, "_err_pulses"}, err_cnt - e0, 1);
        check({name, "_busy"}, busy_seen, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d0;
        logic drop_seen;
        rst_i = 1; start_i = 0; abort_i = 0; base_i = '0; len_i = '0;
        stride_i = '0; passes_i = '0; lane_ready_i = '1; fault_mask = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rd_en", rd_en_o, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_lane_valid", lane_valid_o, 0);
        check("rst_lane_last", lane_last_o, 0);
        check("rst_lane_data", lane_data_o, 0);
        @(posedge clk); #1 rst_i = 0;

        // Job 1: base 0x10, len 4, stride 1, one pass; lane 2 sees 0x4010..0x4013
        expect_job(13'h10, 4, 13'h1, 1);
        @(posedge clk); #1;
        base_i = 13'h10; len_i = 14'd4; stride_i = 13'h1; passes_i = 8'd1; start_i = 1'b1;
        @(negedge clk);
        check("t1_rd_en_start_cycle", rd_en_o, 0);
        check("t1_busy_start_cycle", busy_o, 0);
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("t1_rd_en_cycle1", rd_en_o, 4'hF);
        check("t1_busy_cycle1", busy_o, 1);
        check("t1_lane_valid_cycle1", lane_valid_o, 0);
        check("t1_lane2_addr", rd_addr_o[2*AW +: AW], 15'h4010);
        check("t1_lane0_addr", rd_addr_o[0 +: AW], 15'h0010);
        @(negedge clk);
        check("t1_lane_valid_cycle2", lane_valid_o, 4'hF);
        wait_idle("t1");

        // Job 2: strided two-pass replay, last only on the 6th word
        expect_job(13'h0, 3, 13'h100, 2);
        start_job(13'h0, 14'd3, 13'h100, 8'd2);
        wait_idle("t2");

        // Rejected jobs, then the largest legal span
        try_bad("t3_len0", 13'h0, 14'd0, 13'h1, 8'd1);
        try_bad("t3_span", 13'h1, 14'd2, 13'h1FFF, 8'd1);
        try_bad("t3_pass0", 13'h0, 14'd1, 13'h1, 8'd0);
        expect_job(13'h1FFE, 2, 13'h1, 1);
        start_job(13'h1FFE, 14'd2, 13'h1, 8'd1);
        wait_idle("t3_edge");

        // Lane 1 stalled for 10 cycles mid-job; a start while busy is ignored
        expect_job(13'h20, 20, 13'h1, 1);
        e0 = err_cnt;
        start_job(13'h20, 14'd20, 13'h1, 8'd1);
        repeat (2) @(posedge clk);
        #1 lane_ready_i[1] = 1'b0;
        drop_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rd_en_o[0]) drop_seen = 1'b1;
            if (i == 4) begin
                base_i = 13'h100; len_i = 14'd1; stride_i = 13'h0; passes_i = 8'd1; start_i = 1'b1;
            end
            if (i == 5) start_i = 1'b0;
        end
        check("t4_rd_en_dropped", drop_seen, 1);
        check("t4_rd_en_held_low", rd_en_o, 0);
        check("t4_lane1_valid_stalled", lane_valid_o[1], 1);
        @(posedge clk); #1 lane_ready_i = '1;
        wait_idle("t4");
        #1 check("t4_no_err", err_cnt - e0, 0);

        // Abort with FIFOs partly full; no done, then a clean restart
        lane_ready_i = '0;
        d0 = done_cnt;
        expect_job(13'h0, 10, 13'h1, 1);
        start_job(13'h0, 14'd10, 13'h1, 8'd1);
        @(negedge clk);
        @(negedge clk);
        check("t5_partly_full", lane_valid_o, 4'hF);
        #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
        @(negedge clk);
        check("t5_valid_cleared", lane_valid_o, 0);
        check("t5_busy_cleared", busy_o, 0);
        flush_expect();
        repeat (6) @(negedge clk);
        #1 check("t5_no_done", done_cnt - d0, 0);
        lane_ready_i = '1;
        expect_job(13'h30, 3, 13'h1, 1);
        start_job(13'h30, 14'd3, 13'h1, 8'd1);
        wait_idle("t5_restart");

        // Bank 3 read-valid dropped on one issued read
        expect_job(13'h0, 8, 13'h1, 1);
        @(posedge clk); #1;
        e0 = err_cnt;
        d0 = done_cnt;
        start_job(13'h0, 14'd8, 13'h1, 8'd1);
        @(posedge clk); #1 fault_mask = 4'b1000;
        @(posedge clk); #1 fault_mask = '0;
        @(negedge clk);
        check("t6_busy_cleared", busy_o, 0);
        check("t6_valid_cleared", lane_valid_o, 0);
        flush_expect();
        repeat (3) @(negedge clk);
        #1;
        check("t6_err_pulses", err_cnt - e0, 1);
        check("t6_no_done", done_cnt - d0, 0);
        expect_job(13'h5, 2, 13'h3, 1);
        start_job(13'h5, 14'd2, 13'h3, 8'd1);
        wait_idle("t6_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
